// File: rtl/cfg_frame_sequencer_if.sv
// Bitstream-in / decoder-out bundle of the configuration frame sequencer.
// master is the bitstream source side, slave is the sequencer.
interface cfg_frame_sequencer_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_FRAMES = 29
);
    localparam int FCW = $clog2(NUM_FRAMES + 1);

    logic                  cfg_start;
    logic                  cfg_bit;
    logic                  cfg_bit_valid;
    logic                  cfg_bit_ready;
    logic                  dec_enable;
    logic [0:ADDR_WIDTH-1] dec_address;
    logic                  dec_data_in;
    logic                  cfg_busy;
    logic                  cfg_done;
    logic                  cfg_addr_err;
    logic [FCW-1:0]        frame_count;

    modport master (
        output cfg_start, cfg_bit, cfg_bit_valid,
        input  cfg_bit_ready, dec_enable, dec_address, dec_data_in,
               cfg_busy, cfg_done, cfg_addr_err, frame_count
    );

    modport slave (
        input  cfg_start, cfg_bit, cfg_bit_valid,
        output cfg_bit_ready, dec_enable, dec_address, dec_data_in,
               cfg_busy, cfg_done, cfg_addr_err, frame_count
    );
endinterface

// File: rtl/cfg_frame_sequencer.sv
// Bit-serial configuration sequencer: shifts {address LSB-first, data} frames in
// and strobes the data-in address decoder once per frame.
module cfg_frame_sequencer #(
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_OUTPUTS  = 29,
    parameter int NUM_FRAMES   = 29,
    parameter int WRITE_CYCLES = 1
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset_n,
    cfg_frame_sequencer_if.slave bus
);
    localparam int BCW = $clog2(ADDR_WIDTH + 1);
    localparam int WCW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
    localparam int FCW = $clog2(NUM_FRAMES + 1);
    localparam logic [ADDR_WIDTH:0] OUT_LIM = NUM_OUTPUTS[ADDR_WIDTH:0];

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, HOLD, DONE} state_t;

    state_t                state, state_nxt;
    logic [BCW-1:0]        bit_cnt;
    logic [WCW-1:0]        wr_cnt;
    logic [ADDR_WIDTH-1:0] addr_val;
    logic                  accept, data_bit, addr_ok, write_last, frame_last, start_ok;
    logic                  ready_d, busy_d, enable_d, done_d;

    // dec_address is declared [0:N-1] with index 0 as LSB; rebuild the numeric value
    always_comb begin
        addr_val = '0;
        for (int k = 0; k < ADDR_WIDTH; k++) addr_val[k] = bus.dec_address[k];
    end

    assign addr_ok    = {1'b0, addr_val} < OUT_LIM;
    assign accept     = bus.cfg_bit_valid && bus.cfg_bit_ready && (state == LOAD);
    assign data_bit   = (bit_cnt == BCW'(ADDR_WIDTH));
    assign write_last = (wr_cnt == WCW'(WRITE_CYCLES - 1));
    assign frame_last = (bus.frame_count == FCW'(NUM_FRAMES - 1));
    assign start_ok   = bus.cfg_start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state             <= IDLE;
            bus.cfg_bit_ready <= 1'b0;
            bus.cfg_busy      <= 1'b0;
            bus.dec_enable    <= 1'b0;
            bus.cfg_done      <= 1'b0;
        end else begin
            state             <= state_nxt;
            bus.cfg_bit_ready <= ready_d;
            bus.cfg_busy      <= busy_d;
            bus.dec_enable    <= enable_d;
            bus.cfg_done      <= done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.cfg_start) state_nxt = LOAD;
            LOAD:       if (accept && data_bit) state_nxt = WRITE;
            WRITE:      if (write_last) state_nxt = HOLD;
            HOLD:       state_nxt = frame_last ? DONE : LOAD;
            default:    state_nxt = IDLE;
        endcase
    end

    // Flags are registered from the next state so they line up with the state register
    always_comb begin
        ready_d  = (state_nxt == LOAD);
        busy_d   = (state_nxt == LOAD) || (state_nxt == WRITE) || (state_nxt == HOLD);
        enable_d = (state_nxt == WRITE) && addr_ok;
        done_d   = (state_nxt == DONE);
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            bit_cnt          <= '0;
            wr_cnt           <= '0;
            bus.dec_address  <= '0;
            bus.dec_data_in  <= 1'b0;
            bus.cfg_addr_err <= 1'b0;
            bus.frame_count  <= '0;
        end else begin
            if (start_ok) begin
                bit_cnt          <= '0;
                bus.frame_count  <= '0;
                bus.cfg_addr_err <= 1'b0;
            end
            if (accept) begin
                if (data_bit) begin
                    bus.dec_data_in <= bus.cfg_bit;
                    bit_cnt         <= '0;
                    if (!addr_ok) bus.cfg_addr_err <= 1'b1;
                end else begin
                    for (int k = 0; k < ADDR_WIDTH; k++)
                        if (bit_cnt == BCW'(k)) bus.dec_address[k] <= bus.cfg_bit;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (state == WRITE) wr_cnt <= write_last ? '0 : wr_cnt + 1'b1;
            else                wr_cnt <= '0;
            if (state == HOLD) bus.frame_count <= bus.frame_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_cfg_frame_sequencer.sv
// Randomized bench for cfg_frame_sequencer: two instances (default and a short,
// slow-write variant) checked each cycle against a frame-level reference model.
module tb_cfg_frame_sequencer;
    localparam int AW = 5, NO = 29;
    localparam int NFA = 29, WCA = 1, NFB = 2, WCB = 3;
    localparam int P_IDLE = 0, P_LOAD = 1, P_WRITE = 2, P_HOLD = 3, P_DONE = 4;

    typedef struct {
        int   ph, nb, wl, addr, fc;
        logic data, err;
    } mdl_t;

    logic prog_clk = 1'b0, prog_reset_n = 1'b1;
    logic sel = 1'b0, start = 1'b0, valid = 1'b0, bitv = 1'b0, chk_en = 1'b0;
    logic cur_ready;
    int   total = 0, bad = 0;
    int   en_cnt_a = 0, en_cnt_b = 0, acc_a = 0;
    mdl_t ma, mb;

    always #5 prog_clk = ~prog_clk;

    cfg_frame_sequencer_if #(.ADDR_WIDTH(AW), .NUM_FRAMES(NFA)) ifa();
    cfg_frame_sequencer_if #(.ADDR_WIDTH(AW), .NUM_FRAMES(NFB)) ifb();

    cfg_frame_sequencer #(.ADDR_WIDTH(AW), .NUM_OUTPUTS(NO), .NUM_FRAMES(NFA), .WRITE_CYCLES(WCA))
        dut_a (.prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .bus(ifa.slave));
    cfg_frame_sequencer #(.ADDR_WIDTH(AW), .NUM_OUTPUTS(NO), .NUM_FRAMES(NFB), .WRITE_CYCLES(WCB))
        dut_b (.prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .bus(ifb.slave));

    // only the selected instance sees stimulus; the other sits with inputs low
    assign ifa.cfg_start     = !sel && start;
    assign ifa.cfg_bit_valid = !sel && valid;
    assign ifa.cfg_bit       = !sel && bitv;
    assign ifb.cfg_start     = sel && start;
    assign ifb.cfg_bit_valid = sel && valid;
    assign ifb.cfg_bit       = sel && bitv;
    assign cur_ready = sel ? ifb.cfg_bit_ready : ifa.cfg_bit_ready;

    task automatic chk(input string tag, input logic [31:0] got, input int want);
        total++;
        if (got !== 32'(want)) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h @%0t", tag, got, want, $time);
        end
    endtask

    function automatic mdl_t step(input mdl_t m_in, input logic st, input logic v,
                                  input logic b, input int nf, input int wc);
        mdl_t m = m_in;
        case (m.ph)
            P_IDLE, P_DONE: if (st) begin m.ph = P_LOAD; m.nb = 0; m.fc = 0; m.err = 1'b0; end
            P_LOAD: if (v) begin
                if (m.nb < AW) begin
                    m.addr = b ? (m.addr | (1 << m.nb)) : (m.addr & ~(1 << m.nb));
                    m.nb++;
                end else begin
                    m.data = b; m.ph = P_WRITE; m.wl = wc;
                    if (m.addr >= NO) m.err = 1'b1;
                end
            end
            P_WRITE: begin m.wl--; if (m.wl == 0) m.ph = P_HOLD; end
            default: begin m.fc++; m.nb = 0; m.ph = (m.fc == nf) ? P_DONE : P_LOAD; end
        endcase
        return m;
    endfunction

    function automatic int addr_of(input logic [0:AW-1] a);
        int v = 0;
        for (int k = 0; k < AW; k++) v |= int'(a[k]) << k;
        return v;
    endfunction

    function automatic int exp_pack(input mdl_t m);
        int en = (m.ph == P_WRITE && m.addr < NO) ? 1 : 0;
        int bsy = (m.ph == P_LOAD || m.ph == P_WRITE || m.ph == P_HOLD) ? 1 : 0;
        return (int'(m.ph == P_LOAD) << 21) | (bsy << 20) | (en << 19) | (int'(m.data) << 18) |
               (int'(m.ph == P_DONE) << 17) | (int'(m.err) << 16) | (m.fc << 8) | m.addr;
    endfunction

    function automatic logic [31:0] got_pack(input logic rdy, bsy, en, dat, dn, er,
                                             input int fc, input logic [0:AW-1] a);
        return ({31'd0, rdy} << 21) | ({31'd0, bsy} << 20) | ({31'd0, en} << 19) |
               ({31'd0, dat} << 18) | ({31'd0, dn} << 17) | ({31'd0, er} << 16) |
               32'(fc << 8) | 32'(addr_of(a));
    endfunction

    always @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
        end else begin
            ma <= step(ma, ifa.cfg_start, ifa.cfg_bit_valid, ifa.cfg_bit, NFA, WCA);
            mb <= step(mb, ifb.cfg_start, ifb.cfg_bit_valid, ifb.cfg_bit, NFB, WCB);
        end
    end

    always @(posedge prog_clk) if (ifa.cfg_bit_valid && ifa.cfg_bit_ready) acc_a <= acc_a + 1;

    always @(negedge prog_clk) begin
        if (ifa.dec_enable) en_cnt_a <= en_cnt_a + 1;
        if (ifb.dec_enable) en_cnt_b <= en_cnt_b + 1;
        if (chk_en) begin
            chk("a_cyc", got_pack(ifa.cfg_bit_ready, ifa.cfg_busy, ifa.dec_enable, ifa.dec_data_in,
                ifa.cfg_done, ifa.cfg_addr_err, int'(ifa.frame_count), ifa.dec_address), exp_pack(ma));
            chk("b_cyc", got_pack(ifb.cfg_bit_ready, ifb.cfg_busy, ifb.dec_enable, ifb.dec_data_in,
                ifb.cfg_done, ifb.cfg_addr_err, int'(ifb.frame_count), ifb.dec_address), exp_pack(mb));
            chk("en_rdy", {31'd0, (ifa.dec_enable & ifa.cfg_bit_ready) | (ifb.dec_enable & ifb.cfg_bit_ready)}, 0);
        end
    end

    task automatic tick();
        @(negedge prog_clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit gap);
        int n = 0;
        if (gap) begin valid = 1'b0; tick(); end
        valid = 1'b1;
        bitv  = b;
        while (!cur_ready && n < 40) begin tick(); n++; end
        if (n >= 40) chk("rdy_wait", {31'd0, cur_ready}, 1);
        tick();
    endtask

    task automatic frame(input int addr, input logic d, input bit gap);
        for (int k = 0; k < AW; k++) send_bit(logic'((addr >> k) & 1), gap);
        send_bit(d, gap);
    endtask

    task automatic start_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n, e0, a0, r;
        logic       d;
        logic [0:AW-1] ra, rexp;

        #1 prog_reset_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) tick();
        chk("rst_a", got_pack(ifa.cfg_bit_ready, ifa.cfg_busy, ifa.dec_enable, ifa.dec_data_in,
            ifa.cfg_done, ifa.cfg_addr_err, int'(ifa.frame_count), ifa.dec_address), 0);
        prog_reset_n = 1'b1;
        tick();

        // basic frame: bits 1,1,0,0,0 then data 1 -> address 3
        start_pass();
        e0 = en_cnt_a;
        frame(3, 1'b1, 1'b0);
        valid = 1'b0;
        ra = ifa.dec_address;
        rexp = 5'b11000;
        chk("raw_addr", ra, rexp);
        chk("data1", {31'd0, ifa.dec_data_in}, 1);
        n = 0;
        while (!ifa.cfg_bit_ready && n < 10) begin tick(); n++; end
        chk("rdy_lat", n, 2);
        chk("en_pulse", en_cnt_a - e0, 1);
        chk("fc1", ifa.frame_count, 1);

        // out-of-range address is counted but never written
        e0 = en_cnt_a;
        frame(29, 1'b0, 1'b0);
        valid = 1'b0;
        repeat (2) tick();
        chk("err_set", {31'd0, ifa.cfg_addr_err}, 1);
        chk("en_oor", en_cnt_a - e0, 0);
        chk("fc2", ifa.frame_count, 2);
        frame(0, 1'b1, 1'b0);
        repeat (2) tick();
        chk("en_addr0", en_cnt_a - e0, 1);
        chk("err_sticky", {31'd0, ifa.cfg_addr_err}, 1);

        // valid toggling every other cycle
        e0 = en_cnt_a; a0 = acc_a;
        r = $urandom_range(0, NO - 1); d = logic'($urandom_range(0, 1));
        frame(r, d, 1'b1);
        valid = 1'b0;
        repeat (2) tick();
        chk("acc_gap", acc_a - a0, AW + 1);
        chk("en_gap", en_cnt_a - e0, WCA);
        chk("addr_gap", addr_of(ifa.dec_address), r);
        chk("data_gap", {31'd0, ifa.dec_data_in}, int'(d));

        // start in the middle of LOAD is ignored
        r = $urandom_range(0, NO - 1);
        for (int k = 0; k < 3; k++) send_bit(logic'((r >> k) & 1), 1'b0);
        start = 1'b1;
        send_bit(logic'((r >> 3) & 1), 1'b0);
        start = 1'b0;
        send_bit(logic'((r >> 4) & 1), 1'b0);
        send_bit(1'b1, 1'b0);
        valid = 1'b0;
        repeat (2) tick();
        chk("addr_mid_start", addr_of(ifa.dec_address), r);
        chk("fc5", ifa.frame_count, 5);

        // rest of the pass with random addresses, data and gaps
        for (int f = 5; f < NFA; f++) begin
            frame($urandom_range(0, 31), logic'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin valid = 1'b0; tick(); end
        end
        valid = 1'b0;
        repeat (3) tick();
        chk("done_a", {31'd0, ifa.cfg_done}, 1);
        chk("busy_a", {31'd0, ifa.cfg_busy}, 0);
        chk("fc_a", ifa.frame_count, NFA);
        start_pass();
        chk("restart", {ifa.cfg_done, ifa.cfg_addr_err, 3'd0, ifa.frame_count}, 0);

        // short pass on the second instance
        sel = 1'b1;
        start_pass();
        e0 = en_cnt_b;
        frame(0, 1'b1, 1'b0);
        frame(28, 1'b0, 1'b0);
        valid = 1'b0;
        n = 0;
        while (!ifb.cfg_done && n < 20) begin tick(); n++; end
        chk("done_lat", n, WCB + 1);
        chk("fc_b", ifb.frame_count, NFB);
        chk("busy_b", {31'd0, ifb.cfg_busy}, 0);
        chk("en_b", en_cnt_b - e0, 2 * WCB);
        start_pass();
        chk("restart_b", {ifb.cfg_done, ifb.cfg_addr_err, 3'd0, ifb.frame_count}, 0);

        // reset in the middle of WRITE
        frame(5, 1'b1, 1'b0);
        valid = 1'b0;
        chk("en_pre", {31'd0, ifb.dec_enable}, 1);
        #2 prog_reset_n = 1'b0;
        #1 chk("en_async", {31'd0, ifb.dec_enable}, 0);
        chk("rst_b", got_pack(ifb.cfg_bit_ready, ifb.cfg_busy, ifb.dec_enable, ifb.dec_data_in,
            ifb.cfg_done, ifb.cfg_addr_err, int'(ifb.frame_count), ifb.dec_address), 0);
        tick();
        prog_reset_n = 1'b1;
        e0 = en_cnt_b;
        for (int k = 0; k < 6; k++) begin
            valid = logic'($urandom_range(0, 1)); bitv = logic'($urandom_range(0, 1));
            tick();
        end
        valid = 1'b0;
        chk("quiet", {ifb.cfg_bit_ready, ifb.cfg_busy, 3'd0, ifb.frame_count}, 0);
        chk("quiet_en", en_cnt_b - e0, 0);
        start_pass();
        frame(7, 1'b0, 1'b0);
        chk("addr_after_rst", addr_of(ifb.dec_address), 7);

        repeat (6) tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
